mmio_uart_tx: RTL

Memory-mapped UART transmitter on the processor's data-memory write bus, downstream of `top`. It watches dmem_write/dmem_addr/dmem_write_data. Bytes written to a TX address enter a small FIFO and are serialised as 8N1 frames on a single output line. This gives programs a visible output channel alongside the existing store-checking benches.

---
 rtl/mmio_uart_tx.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter snooping the data-memory store bus.
// Stores to TX_ADDR queue a byte in a small circular FIFO; the serialiser
// drains it LSB first, CLKS_PER_BIT clocks per bit, back-to-back when queued.
module mmio_uart_tx #(
    parameter logic [31:0] TX_ADDR      = 32'h0000_00F0,
    parameter logic [31:0] STATUS_ADDR  = 32'h0000_00F4,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dmem_write,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_write_data,
    output logic        tx,
    output logic        tx_busy,
    output logic        fifo_empty,
    output logic        fifo_full,
    output logic        overflow,
    output logic [31:0] status
);

    localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);

    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0]  CntFull  = CntW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e            state_q;
    logic [BaudW-1:0]  baud_q;
    logic [2:0]        bit_idx_q;
    logic [7:0]        shift_q;
    logic              tx_q;

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              overflow_q, overflow_d;

    logic              baud_done;
    logic              fifo_nempty;
    logic              pop;
    logic              push_req;
    logic              push_ok;
    logic              drop;
    logic              clear_req;
    logic [7:0]        head;

    // Only the low byte of store data is ever consumed.
    logic              unused_data;
    assign unused_data = ^dmem_write_data[31:8];

    // Pop decisions and bus decode.
    always_comb begin
        baud_done   = (baud_q == BaudLast);
        fifo_nempty = (count_q != '0);
        head        = mem_q[rd_ptr_q];
        pop         = fifo_nempty &&
                      ((state_q == StIdle) || ((state_q == StStop) && baud_done));
        push_req    = dmem_write && (dmem_addr == TX_ADDR);
        // A full FIFO still accepts a push when the head leaves on the same edge.
        push_ok     = push_req && ((count_q != CntFull) || pop);
        drop        = push_req && !push_ok;
        clear_req   = dmem_write && (dmem_addr == STATUS_ADDR) && dmem_write_data[0];
    end

    // FIFO pointer, occupancy and sticky overflow next-state.
    always_comb begin
        wr_ptr_d   = push_ok ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d    = count_q;
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
        // A drop on the same edge as a clear leaves the flag set.
        overflow_d = overflow_q;
        if (clear_req) overflow_d = 1'b0;
        if (drop)      overflow_d = 1'b1;
    end

    // FIFO control state.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage; contents are don't-care while count is zero.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= dmem_write_data[7:0];
        end
    end

    // Serialiser FSM with registered line output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    baud_q <= '0;
                    if (pop) begin
                        shift_q <= head;
                        tx_q    <= 1'b0;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (baud_done) begin
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        tx_q      <= shift_q[0];
                        state_q   <= StData;
                    end else begin
                        baud_q <= baud_q + BaudW'(1);
                    end
                end
                StData: begin
                    if (baud_done) begin
                        baud_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= StStop;
                        end else begin
                            shift_q   <= {1'b0, shift_q[7:1]};
                            tx_q      <= shift_q[1];
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q + BaudW'(1);
                    end
                end
                StStop: begin
                    if (baud_done) begin
                        baud_q <= '0;
                        if (pop) begin
                            shift_q <= head;
                            tx_q    <= 1'b0;
                            state_q <= StStart;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        baud_q <= baud_q + BaudW'(1);
                    end
                end
                default: begin
                    baud_q  <= '0;
                    tx_q    <= 1'b1;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Status outputs decoded from registers only.
    always_comb begin
        tx         = tx_q;
        tx_busy    = (state_q != StIdle);
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CntFull);
        overflow   = overflow_q;
        status     = {28'b0, overflow_q, fifo_full, fifo_empty, tx_busy};
    end

endmodule
